// File: rtl/seq_slice_adder_pkg.sv
// ac_pkg: shared slice width, FSM state type and slice-count helper for seq_slice_adder
package ac_pkg;
    localparam int SLICE_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/seq_slice_adder_byte_carry_chain.sv
// byte_carry_chain: combinational ripple carry over one 8-bit slice from generate/propagate terms
module byte_carry_chain
    import ac_pkg::*;
(
    input  logic [SLICE_W-1:0] i_g_n,
    input  logic [SLICE_W-1:0] i_p,
    input  logic               i_c0,
    output logic [SLICE_W:1]   o_c
);
    logic w_c;
    always_comb begin
        w_c = i_c0;
        o_c = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            w_c        = ~i_g_n[i] | (i_p[i] & w_c);
            o_c[i + 1] = w_c;
        end
    end
endmodule

// File: rtl/seq_slice_adder.sv
// seq_slice_adder: multi-cycle adder/subtractor resolving one 8-bit slice per clock, LSB first
module seq_slice_adder
    import ac_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_op_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int IW     = $clog2(NSLICE) + 1;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic [IW-1:0]      r_idx;
    logic               r_carry, r_cout, r_ovf;
    logic [SLICE_W-1:0] w_a_s, w_b_s, w_p, w_s;
    logic [SLICE_W:1]   w_c;
    logic [NSLICE-1:0]  w_we;
    logic               w_accept, w_last;

    assign w_accept = (r_state == IDLE) && i_in_valid;
    assign w_last   = r_idx == IW'(NSLICE - 1);
    assign w_a_s    = r_a[SLICE_W*r_idx +: SLICE_W];
    assign w_b_s    = r_b[SLICE_W*r_idx +: SLICE_W];
    assign w_p      = w_a_s ^ w_b_s;
    assign w_s      = w_p ^ {w_c[SLICE_W-1:1], r_carry};
    assign w_we     = (r_state == RUN) ? NSLICE'(1) << r_idx : '0;

    byte_carry_chain u_chain (
        .i_g_n (~(w_a_s & w_b_s)),
        .i_p   (w_p),
        .i_c0  (r_carry),
        .o_c   (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && i_in_valid)  ? RUN  :
                 (r_state == RUN  && w_last)      ? DONE :
                 (r_state == DONE && i_out_ready) ? IDLE : r_state;
    end

    always_comb begin
        o_in_ready  = r_state == IDLE;
        o_out_valid = r_state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_op_sub ? ~i_b : i_b;
                r_carry <= i_op_sub | i_cin;
                r_idx   <= '0;
                r_sum   <= '0;
            end
            if (r_state == RUN) begin
                for (int k = 0; k < NSLICE; k++)
                    if (w_we[k]) r_sum[k*SLICE_W +: SLICE_W] <= w_s;
                r_carry <= w_c[SLICE_W];
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_c[SLICE_W];
                    r_ovf  <= w_c[SLICE_W-1] ^ w_c[SLICE_W];
                end
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_seq_slice_adder.sv
// tb_seq_slice_adder: directed and random checks of seq_slice_adder against a whole-word arithmetic model
module tb_seq_slice_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0, i_cin = 1'b0, i_op_sub = 1'b0, i_out_ready = 1'b0;
    logic [31:0] i_a = '0, i_b = '0;
    logic        o_in_ready, o_out_valid, o_cout, o_ovf;
    logic [31:0] o_sum;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    seq_slice_adder #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_op_sub(i_op_sub),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] t;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
        return {(a[31] == bb[31]) && (t[31] != a[31]), t};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        i_a = a; i_b = b; i_cin = cin; i_op_sub = sub; i_in_valid = 1'b1;
        check("in_ready_before_accept", 64'(o_in_ready), 64'd1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int lat = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
    endtask

    task automatic check_result(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        logic [33:0] m;
        m = model(a, b, cin, sub);
        check("sum", 64'(o_sum), 64'(m[31:0]));
        check("cout", 64'(o_cout), 64'(m[32]));
        check("ovf", 64'(o_ovf), 64'(m[33]));
        check("in_ready_in_done", 64'(o_in_ready), 64'd0);
    endtask

    task automatic finish_op();
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        check("out_valid_after_handshake", 64'(o_out_valid), 64'd0);
        check("in_ready_after_handshake", 64'(o_in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        start_op(a, b, cin, sub);
        wait_done();
        check_result(a, b, cin, sub);
        finish_op();
    endtask

    initial begin
        logic [31:0] ra, rb, hs;
        logic        rc, rs, hc, ho;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 64'(o_sum), 64'd0);
        check("rst_in_ready", 64'(o_in_ready), 64'd1);
        check("rst_out_valid", 64'(o_out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("carry_chain_sum", 64'(o_sum), 64'd0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'd5, 32'd7, 1'b1, 1'b1);
        run_op(32'd7, 32'd5, 1'b0, 1'b1);
        run_op(32'h0000_00FF, 32'd0, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);

        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        wait_done();
        hs = o_sum; hc = o_cout; ho = o_ovf;
        i_a = 32'h1111_1111; i_b = 32'h2222_2222; i_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_sum", 64'(o_sum), 64'(hs));
            check("bp_cout", 64'(o_cout), 64'(hc));
            check("bp_ovf", 64'(o_ovf), 64'(ho));
            check("bp_in_ready", 64'(o_in_ready), 64'd0);
            check("bp_out_valid", 64'(o_out_valid), 64'd1);
        end
        check_result(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        i_in_valid = 1'b0;
        finish_op();

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_sum", 64'(o_sum), 64'd0);
        check("midrun_rst_cout", 64'(o_cout), 64'd0);
        check("midrun_rst_ovf", 64'(o_ovf), 64'd0);
        check("midrun_rst_out_valid", 64'(o_out_valid), 64'd0);
        check("midrun_rst_in_ready", 64'(o_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        check("post_rst_sum", 64'(o_sum), 64'h2345_6789);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom); rs = 1'($urandom);
            if (n % 8 == 0) rb = ~ra;
            run_op(ra, rb, rc, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
